linebuf_window: RTL and testbench
=================================

# linebuf_window

Parametrised K-row line buffer that turns a raster pixel stream into K×K sliding windows for the NPU convolution engine. Stores K+1 rows of COLS pixels in a circular row store, so the next row can be written while K rows are being read. It emits one registered K×K window per cycle under a valid/consume handshake and applies back-pressure to the pixel source when every row slot is occupied.

## Interface
- WIDTH, 8: pixel width in bits.
- COLS, 6: pixels per image row; must be ≥ K.
- K, 3: kernel size (window height and width); must be ≥ 1.
- i_clk  input  1: clock; all logic on the rising edge.
- i_rst  input  1: reset, synchronous, active-high.
- i_wr_en  input  1: pixel write strobe; accepted only when o_wr_ready=1.
- i_data  input  WIDTH: pixel, raster order.
- o_wr_ready  output  1: a free pixel slot exists.
- i_rd_en  input  1: consume current window; ignored when o_valid=0.
- o_valid  output  1: o_data holds a valid window.
- o_data  output  K*K*WIDTH: window; element (r,c) at bits [(r*K+c)*WIDTH +: WIDTH], r=0 oldest row, c=0 leftmost column.

## Operation
- Storage: K+1 row slots × COLS entries, not reset. Counters: wr_col (0..COLS-1), wr_slot (0..K), rd_col (0..COLS-K), rd_slot (0..K, oldest read row), rows_full (0..K+1).
- Write: accepted when i_wr_en && o_wr_ready; stores at [wr_slot][wr_col]; wr_col increments. At wr_col=COLS-1, wr_col→0, wr_slot→(wr_slot+1) mod (K+1), rows_full+1.
- o_wr_ready = (rows_full < K+1), combinational from registered state. Writes while not ready are dropped; no state changes.
- Load condition: rows_full ≥ K && (!o_valid || i_rd_en). On load, o_data captures rows rd_slot..rd_slot+K-1 (mod K+1) at columns rd_col..rd_col+K-1, o_valid←1, rd_col+1.
- Band end: on a load with rd_col=COLS-K, rd_col→0, rd_slot→(rd_slot+1) mod (K+1), rows_full−1. This releases the oldest row.
- Consume without load (i_rd_en, o_valid, rows_full<K): o_valid←0, o_data holds its last value.
- Row complete and row release on the same edge: rows_full unchanged.
- The slot being written is never one of the K read slots, so a write and a read never touch the same entry.

## Timing
- Reset: o_valid=0, o_data=0, o_wr_ready=1, all counters 0.
- Latency: the edge that writes the last pixel of the K-th buffered row increments rows_full. o_valid asserts on the next edge.
- Throughput: one window per cycle while i_rd_en is held and rows_full ≥ K. Each row band gives COLS-K+1 windows.
- Write throughput: one pixel per cycle while o_wr_ready=1. o_wr_ready reflects the previous edge.
- Reset mid-operation: all buffered rows are discarded and the output returns to reset values on the next edge. Storage contents are stale and never exposed.

## Configuration
- LINEBUF_OVERFLOW_FLAG_EN defined: adds output o_overflow (1 bit, reset 0).
  - Sticky; set on any edge where i_wr_en=1 && o_wr_ready=0.
  - Cleared only by i_rst.
- LINEBUF_OVERFLOW_FLAG_EN undefined: port absent; dropped writes are silent.

## Test plan
Defaults WIDTH=8, COLS=6, K=3; pixel value = row*6+col.
- Fill: write pixels 0..17, i_rd_en=0 -> o_valid=1 one edge after the write of 17; o_data elements = {0,1,2,6,7,8,12,13,14}.
- Band sweep: then hold i_rd_en=1 -> windows starting at col 0,1,2,3 on consecutive cycles (last window {3,4,5,9,10,11,15,16,17}) -> o_valid=0 -> o_wr_ready stays 1.
- Back-pressure: write 24 pixels with no reads -> o_wr_ready=0 after pixel 23. Then a 25th write with value 99 -> dropped; o_overflow=1 if the macro is defined. After one band is consumed, the next accepted pixel is 24.
- Streaming: continuous writes and reads over 5 rows -> windows rows 0-2, 1-3, 2-4 are correct, with no lost or duplicated pixels. Check an edge with a simultaneous row complete and row release: rows_full is unchanged.
- Reset mid-band: assert i_rst after window col 1 -> o_valid=0, o_data=0, o_wr_ready=1. Refill pixels 0..17 -> first window is {0,1,2,6,7,8,12,13,14}.
- Params K=1, COLS=4 -> each accepted pixel yields exactly one 1×1 window equal to that pixel.

Source files
------------

// File: rtl/linebuf_window_if.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_window_if
//  Description : Pixel-write and window-read handshake bundle for the K-row
//                line buffer. The master drives pixels in and consumes
//                windows; the slave is the line buffer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface linebuf_window_if #(
    parameter int WIDTH = 8,
    parameter int K     = 3
);
    logic                   i_wr_en;
    logic [WIDTH-1:0]       i_data;
    logic                   o_wr_ready;
    logic                   i_rd_en;
    logic                   o_valid;
    logic [K*K*WIDTH-1:0]   o_data;

    modport master (
        output i_wr_en, i_data, i_rd_en,
        input  o_wr_ready, o_valid, o_data
    );

    modport slave (
        input  i_wr_en, i_data, i_rd_en,
        output o_wr_ready, o_valid, o_data
    );
endinterface
`default_nettype wire

// File: rtl/linebuf_window.sv
`default_nettype none
// ============================================================================
//  Module      : linebuf_window
//  Description : K-row line buffer producing registered KxK sliding windows
//                from a raster pixel stream. K+1 row slots form a circular
//                row store so the next row fills while K rows are read.
//                Optional macro LINEBUF_OVERFLOW_FLAG_EN adds a sticky
//                o_overflow flag for writes attempted while not ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module linebuf_window #(
    parameter int WIDTH = 8,
    parameter int COLS  = 6,
    parameter int K     = 3
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
`ifdef LINEBUF_OVERFLOW_FLAG_EN
    output logic               o_overflow,
`endif
    linebuf_window_if.slave    bus
);

    localparam int c_col_w  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_slot_w = $clog2(K + 1);
    localparam int c_full_w = $clog2(K + 2);
    localparam int c_win_w  = K * K * WIDTH;

    localparam logic [c_col_w-1:0]  c_wr_col_last = c_col_w'(COLS - 1);
    localparam logic [c_col_w-1:0]  c_rd_col_last = c_col_w'(COLS - K);
    localparam logic [c_slot_w-1:0] c_slot_last   = c_slot_w'(K);
    localparam logic [c_full_w-1:0] c_full_max    = c_full_w'(K + 1);
    localparam logic [c_full_w-1:0] c_full_k      = c_full_w'(K);
    localparam logic [c_slot_w:0]   c_nslots_ext  = (c_slot_w + 1)'(K + 1);

    // Row store: contents are never reset; only counters decide visibility.
    logic [WIDTH-1:0]     r_mem [0:K][0:COLS-1];

    logic [c_col_w-1:0]   r_wr_col;
    logic [c_slot_w-1:0]  r_wr_slot;
    logic [c_col_w-1:0]   r_rd_col;
    logic [c_slot_w-1:0]  r_rd_slot;
    logic [c_full_w-1:0]  r_rows_full;
    logic                 r_valid;
    logic [c_win_w-1:0]   r_data;

    logic                 w_wr_ready;
    logic                 w_wr_acc;
    logic                 w_row_done;
    logic                 w_load;
    logic                 w_band_end;
    logic [c_win_w-1:0]   w_window;

    assign w_wr_ready = (r_rows_full < c_full_max);
    assign w_wr_acc   = bus.i_wr_en && w_wr_ready;
    assign w_row_done = w_wr_acc && (r_wr_col == c_wr_col_last);
    assign w_load     = (r_rows_full >= c_full_k) && (!r_valid || bus.i_rd_en);
    assign w_band_end = w_load && (r_rd_col == c_rd_col_last);

    assign bus.o_wr_ready = w_wr_ready;
    assign bus.o_valid    = r_valid;
    assign bus.o_data     = r_data;

    // Window gather: row r of the window lives in slot (rd_slot + r) mod (K+1).
    for (genvar gr = 0; gr < K; gr++) begin : g_row
        logic [c_slot_w:0]   w_sum;
        logic [c_slot_w-1:0] w_slot;

        assign w_sum = {1'b0, r_rd_slot} + (c_slot_w + 1)'(gr);

        // Wrap the slot index back into 0..K.
        always_comb begin
            w_slot = w_sum[c_slot_w-1:0];
            if (w_sum >= c_nslots_ext) begin
                w_slot = w_sum[c_slot_w-1:0] - c_slot_w'(K + 1);
            end
        end

        for (genvar gc = 0; gc < K; gc++) begin : g_col
            assign w_window[(gr*K + gc)*WIDTH +: WIDTH] =
                r_mem[w_slot][r_rd_col + c_col_w'(gc)];
        end
    end

    // Pixel store write; the written slot is never among the K read slots.
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_slot][r_wr_col] <= bus.i_data;
        end
    end

    // Write pointer: column within the row, then row slot around the ring.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_col  <= '0;
            r_wr_slot <= '0;
        end else if (w_wr_acc) begin
            if (r_wr_col == c_wr_col_last) begin
                r_wr_col  <= '0;
                r_wr_slot <= (r_wr_slot == c_slot_last) ? '0
                                                        : r_wr_slot + c_slot_w'(1);
            end else begin
                r_wr_col <= r_wr_col + c_col_w'(1);
            end
        end
    end

    // Window output register and read pointer (column, then oldest row slot).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_rd_col  <= '0;
            r_rd_slot <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_window;
            if (w_band_end) begin
                r_rd_col  <= '0;
                r_rd_slot <= (r_rd_slot == c_slot_last) ? '0
                                                        : r_rd_slot + c_slot_w'(1);
            end else begin
                r_rd_col <= r_rd_col + c_col_w'(1);
            end
        end else if (bus.i_rd_en && r_valid) begin
            r_valid <= 1'b0;
        end
    end

    // Occupied-row count: +1 on row complete, -1 on band release, both cancel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rows_full <= '0;
        end else if (w_row_done && !w_band_end) begin
            r_rows_full <= r_rows_full + c_full_w'(1);
        end else if (!w_row_done && w_band_end) begin
            r_rows_full <= r_rows_full - c_full_w'(1);
        end
    end

`ifdef LINEBUF_OVERFLOW_FLAG_EN
    logic r_overflow;

    assign o_overflow = r_overflow;

    // Sticky flag for any write attempted while the store is full.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (bus.i_wr_en && !w_wr_ready) begin
            r_overflow <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_linebuf_window.sv
`default_nettype none
// ============================================================================
//  Module      : tb_linebuf_window
//  Description : Self-checking bench for linebuf_window. Instance 0 uses
//                K=3, COLS=6 with directed vectors plus random traffic;
//                instance 1 uses K=1, COLS=4 with random traffic. Both are
//                compared every cycle to a pixel-queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_linebuf_window;

    localparam int WIDTH = 8;
    localparam int COLS  = 6;
    localparam int K     = 3;
    localparam int W0    = COLS - K + 1;
    localparam int COLS1 = 4;
    localparam int K1    = 1;
    localparam int W1    = COLS1 - K1 + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    linebuf_window_if #(.WIDTH(WIDTH), .K(K))  bus0();
    linebuf_window_if #(.WIDTH(WIDTH), .K(K1)) bus1();

`ifdef LINEBUF_OVERFLOW_FLAG_EN
    logic ovf0, ovf1;
`endif

    linebuf_window #(.WIDTH(WIDTH), .COLS(COLS), .K(K)) dut0 (
        .i_clk      (clk),
        .i_rst      (rst),
`ifdef LINEBUF_OVERFLOW_FLAG_EN
        .o_overflow (ovf0),
`endif
        .bus        (bus0)
    );

    linebuf_window #(.WIDTH(WIDTH), .COLS(COLS1), .K(K1)) dut1 (
        .i_clk      (clk),
        .i_rst      (rst),
`ifdef LINEBUF_OVERFLOW_FLAG_EN
        .o_overflow (ovf1),
`endif
        .bus        (bus1)
    );

    int nchecks = 0;
    int nerrs   = 0;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Window of the test-plan image (pixel = row*COLS + col) for band b, column c.
    function automatic logic [71:0] win(input int b, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int cc = 0; cc < K; cc++)
                w[(r*K + cc)*8 +: 8] = 8'((b + r)*COLS + c + cc);
        return w;
    endfunction

    // ---------------- reference model, instance 0 ----------------
    // Accepted pixels are kept in arrival order; the n-th window loaded is
    // band n/W, column n%W. Occupied rows = complete rows - released bands.
    logic [7:0]  pa0[$];
    int          nacc0, nload0, rf0;
    bit          rdy0, ld0;
    logic        mvalid0, movf0;
    logic [71:0] mdata0;

    always @(posedge clk) begin
        if (rst) begin
            pa0.delete();
            nacc0 = 0; nload0 = 0; mvalid0 = 1'b0; mdata0 = '0; movf0 = 1'b0;
        end else begin
            rf0  = nacc0/COLS - nload0/W0;
            rdy0 = (rf0 < K + 1);
            ld0  = (rf0 >= K) && (!mvalid0 || bus0.i_rd_en);
            if (bus0.i_wr_en && !rdy0) movf0 = 1'b1;
            if (ld0) begin
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        mdata0[(r*K + c)*8 +: 8] = pa0[(nload0/W0 + r)*COLS + nload0%W0 + c];
                mvalid0 = 1'b1;
                nload0++;
            end else if (bus0.i_rd_en && mvalid0) begin
                mvalid0 = 1'b0;
            end
            if (bus0.i_wr_en && rdy0) begin
                pa0.push_back(bus0.i_data);
                nacc0++;
            end
        end
    end

    // ---------------- reference model, instance 1 ----------------
    logic [7:0]  pa1[$];
    int          nacc1, nload1, rf1;
    bit          rdy1, ld1;
    logic        mvalid1, movf1;
    logic [7:0]  mdata1;

    always @(posedge clk) begin
        if (rst) begin
            pa1.delete();
            nacc1 = 0; nload1 = 0; mvalid1 = 1'b0; mdata1 = '0; movf1 = 1'b0;
        end else begin
            rf1  = nacc1/COLS1 - nload1/W1;
            rdy1 = (rf1 < K1 + 1);
            ld1  = (rf1 >= K1) && (!mvalid1 || bus1.i_rd_en);
            if (bus1.i_wr_en && !rdy1) movf1 = 1'b1;
            if (ld1) begin
                mdata1  = pa1[nload1];
                mvalid1 = 1'b1;
                nload1++;
            end else if (bus1.i_rd_en && mvalid1) begin
                mvalid1 = 1'b0;
            end
            if (bus1.i_wr_en && rdy1) begin
                pa1.push_back(bus1.i_data);
                nacc1++;
            end
        end
    end

    // Compare both DUTs against their models away from the active edge.
    always @(negedge clk) begin
        chk("m0_ready", 72'(bus0.o_wr_ready), 72'((nacc0/COLS - nload0/W0) < K + 1));
        chk("m0_valid", 72'(bus0.o_valid), 72'(mvalid0));
        chk("m0_data",  72'(bus0.o_data), mdata0);
        chk("m1_ready", 72'(bus1.o_wr_ready), 72'((nacc1/COLS1 - nload1/W1) < K1 + 1));
        chk("m1_valid", 72'(bus1.o_valid), 72'(mvalid1));
        chk("m1_data",  72'(bus1.o_data), 72'(mdata1));
`ifdef LINEBUF_OVERFLOW_FLAG_EN
        chk("m0_ovf", 72'(ovf0), 72'(movf0));
        chk("m1_ovf", 72'(ovf1), 72'(movf1));
`endif
    end

    // One clock of stimulus; instance 1 always receives random traffic.
    task automatic step(input bit w, input logic [7:0] d, input bit r);
        bus0.i_wr_en = w;
        bus0.i_data  = d;
        bus0.i_rd_en = r;
        bus1.i_wr_en = ($urandom_range(0, 3) != 0);
        bus1.i_data  = 8'($urandom);
        bus1.i_rd_en = ($urandom_range(0, 2) != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill18();
        for (int k = 0; k < 18; k++) step(1'b1, 8'(k), 1'b0);
    endtask

    typedef struct {
        bit          wr;
        logic [7:0]  d;
        bit          rd;
        bit          ev;
        bit          er;
        logic [71:0] ed;
    } vec_t;

    function automatic vec_t mk(input bit wr, input int d, input bit rd,
                                input bit ev, input bit er, input logic [71:0] ed);
        vec_t v;
        v.wr = wr; v.d = 8'(d); v.rd = rd; v.ev = ev; v.er = er; v.ed = ed;
        return v;
    endfunction

    initial begin
        vec_t tv[$];

        // Fill then band sweep as one table of per-cycle expectations.
        for (int k = 0; k < 18; k++) tv.push_back(mk(1'b1, k, 1'b0, 1'b0, 1'b1, '0));
        tv.push_back(mk(1'b0, 0, 1'b0, 1'b1, 1'b1, win(0, 0)));
        tv.push_back(mk(1'b0, 0, 1'b1, 1'b1, 1'b1, win(0, 1)));
        tv.push_back(mk(1'b0, 0, 1'b1, 1'b1, 1'b1, win(0, 2)));
        tv.push_back(mk(1'b0, 0, 1'b1, 1'b1, 1'b1, win(0, 3)));
        tv.push_back(mk(1'b0, 0, 1'b1, 1'b0, 1'b1, win(0, 3)));
        tv.push_back(mk(1'b0, 0, 1'b0, 1'b0, 1'b1, win(0, 3)));

        rst = 1'b1;
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);
        chk("reset_valid", 72'(bus0.o_valid), 72'(0));
        chk("reset_data",  72'(bus0.o_data), 72'(0));
        chk("reset_ready", 72'(bus0.o_wr_ready), 72'(1));
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].wr, tv[i].d, tv[i].rd);
            chk($sformatf("vec%0d_valid", i), 72'(bus0.o_valid), 72'(tv[i].ev));
            chk($sformatf("vec%0d_ready", i), 72'(bus0.o_wr_ready), 72'(tv[i].er));
            chk($sformatf("vec%0d_data", i),  72'(bus0.o_data), tv[i].ed);
        end

        // Back-pressure: four rows with no reads fill every slot.
        rst = 1'b1; step(1'b0, 8'd0, 1'b0); rst = 1'b0;
        for (int k = 0; k < 24; k++) begin
            step(1'b1, 8'(k), 1'b0);
            if (k == 22) chk("bp_ready_22", 72'(bus0.o_wr_ready), 72'(1));
            if (k == 23) chk("bp_ready_23", 72'(bus0.o_wr_ready), 72'(0));
        end
        step(1'b1, 8'd99, 1'b0);
        chk("bp_drop_ready", 72'(bus0.o_wr_ready), 72'(0));
`ifdef LINEBUF_OVERFLOW_FLAG_EN
        chk("bp_overflow", 72'(ovf0), 72'(1));
`endif
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("bp_still_full", 72'(bus0.o_wr_ready), 72'(0));
        step(1'b0, 8'd0, 1'b1);
        chk("bp_released", 72'(bus0.o_wr_ready), 72'(1));
        for (int k = 24; k < 30; k++) step(1'b1, 8'(k), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'd0, 1'b1);
        chk("bp_band2_valid", 72'(bus0.o_valid), 72'(1));
        chk("bp_band2_data",  72'(bus0.o_data), win(2, 0));

        // Reset in the middle of a band, then refill.
        rst = 1'b1; step(1'b0, 8'd0, 1'b0); rst = 1'b0;
        fill18();
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b1);
        chk("mid_col1", 72'(bus0.o_data), win(0, 1));
        rst = 1'b1;
        step(1'b1, 8'd55, 1'b1);
        rst = 1'b0;
        chk("mid_rst_valid", 72'(bus0.o_valid), 72'(0));
        chk("mid_rst_data",  72'(bus0.o_data), 72'(0));
        chk("mid_rst_ready", 72'(bus0.o_wr_ready), 72'(1));
        fill18();
        step(1'b0, 8'd0, 1'b0);
        chk("refill_valid", 72'(bus0.o_valid), 72'(1));
        chk("refill_data",  72'(bus0.o_data), win(0, 0));

        // Streaming with a row completing on the same edge as a band release.
        rst = 1'b1; step(1'b0, 8'd0, 1'b0); rst = 1'b0;
        fill18();
        for (int k = 18; k < 21; k++) step(1'b1, 8'(k), 1'b0);
        for (int k = 21; k < 24; k++) step(1'b1, 8'(k), 1'b1);
        chk("coinc_ready", 72'(bus0.o_wr_ready), 72'(1));
        chk("coinc_data",  72'(bus0.o_data), win(0, 3));
        step(1'b1, 8'd24, 1'b1);
        chk("coinc_next_valid", 72'(bus0.o_valid), 72'(1));
        chk("coinc_next_data",  72'(bus0.o_data), win(1, 0));
        for (int k = 25; k < 30; k++) step(1'b1, 8'(k), 1'b1);
        step(1'b0, 8'd0, 1'b1);
        chk("stream_band2_c0", 72'(bus0.o_data), win(2, 0));
        for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b1);
        chk("stream_band2_c3", 72'(bus0.o_data), win(2, 3));
        step(1'b0, 8'd0, 1'b1);
        chk("stream_drained", 72'(bus0.o_valid), 72'(0));

        // Random traffic with occasional resets; the models check every cycle.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;
        step(1'b0, 8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
`default_nettype wire
